// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: two requesters share one 32-bit ripple-carry adder, round-robin granted (optional ADDER_ARB_SUB_EN adds subtract ports).
// Latency: operands held SETTLE_CYCLES clocks after accept, then the sum is registered; one op per SETTLE_CYCLES+2 clocks.
// Backpressure: reqN_ready only in IDLE; rsp_ready low holds the response stable and blocks further accepts.

// Plain ripple-carry chain; it sits on a multi-cycle path behind the operand registers.
module thirty_two_bits_full_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic [32:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[32];
endmodule

module adder_share_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
`ifdef ADDER_ARB_SUB_EN
    input  logic             req0_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
`ifdef ADDER_ARB_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rr_ptr_q, rr_ptr_d;   // last grantee; 1 after reset so req0 wins first
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_id_q, rsp_id_d;

    logic             gnt0, gnt1;
    logic [WIDTH-1:0] b0_eff, b1_eff;
    logic             cin0_eff, cin1_eff;
    logic [WIDTH-1:0] sum_s;
    logic             sum_cout;

    // Operand B / carry-in as presented to the adder; subtraction is A + ~B + 1.
`ifdef ADDER_ARB_SUB_EN
    always_comb begin
        b0_eff   = req0_sub ? ~req0_b : req0_b;
        b1_eff   = req1_sub ? ~req1_b : req1_b;
        cin0_eff = req0_sub ? 1'b1 : req0_cin;
        cin1_eff = req1_sub ? 1'b1 : req1_cin;
    end
`else
    always_comb begin
        b0_eff   = req0_b;
        b1_eff   = req1_b;
        cin0_eff = req0_cin;
        cin1_eff = req1_cin;
    end
`endif

    // Round-robin grant, only while idle and out of reset; at most one grant at a time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                gnt0 = rr_ptr_q;
                gnt1 = !rr_ptr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    thirty_two_bits_full_adder u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .s    (sum_s),
        .cout (sum_cout)
    );

    // Next-state: accept in IDLE, count down the settle window, hold the response until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d      = gnt1 ? req1_a : req0_a;
                    b_d      = gnt1 ? b1_eff : b0_eff;
                    cin_d    = gnt1 ? cin1_eff : cin0_eff;
                    id_d     = gnt1;
                    rr_ptr_d = gnt1;
                    cnt_d    = CNT_INIT;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_s_d     = sum_s;
                    rsp_cout_d  = sum_cout;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Returning to IDLE leaves one bubble before the next accept.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rr_ptr_q    <= 1'b1;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Operand registers need no reset: they are only observed after a grant loads them.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        cin_q <= cin_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);
endmodule
